// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Debounces one active-low mechanical push-button. A three-stage
//               synchroniser feeds edge detection and a four-state filter FSM
//               that requires CNT_MAX+1 stable clocks before confirming a
//               press or release. Emits a single-cycle key_flag pulse plus the
//               debounced level key_state (1 = released, 0 = pressed).
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int CNT_MAX = 999_999,
    parameter int CNT_W   = 20
) (
    input  logic Clk,
    input  logic Rst,
    input  logic key_in,
    output logic key_flag,
    output logic key_state
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_FILTER0 = 2'd1;
    localparam logic [1:0] c_DOWN    = 2'd2;
    localparam logic [1:0] c_FILTER1 = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic             r_s0;
    logic             r_s1;
    logic             r_s2;
    logic             w_nedge;
    logic             w_pedge;
    logic             w_cnt_done;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    // Bring the asynchronous pin into the clock domain; reset to "released"
    // so that a key held low across reset still produces a press edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s0 <= key_in;
            r_s1 <= r_s0;
            r_s2 <= r_s1;
        end
    end

    // Edges are taken between the two settled stages only; r_s0 may still be
    // metastable and must not reach the FSM.
    assign w_nedge    = r_s2 & ~r_s1;
    assign w_pedge    = ~r_s2 & r_s1;
    assign w_cnt_done = (r_cnt == c_CNT_MAX);

    // Filter FSM: any opposite edge during a window aborts it silently, and
    // that abort takes priority over a window completing in the same cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= c_CNT_ZERO;
            key_flag  <= 1'b0;
            key_state <= 1'b1;
        end else begin
            key_flag <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_cnt <= c_CNT_ZERO;
                    if (w_nedge) begin
                        r_state <= c_FILTER0;
                    end
                end
                c_FILTER0: begin
                    if (w_pedge) begin
                        r_state <= c_IDLE;
                        r_cnt   <= c_CNT_ZERO;
                    end else if (w_cnt_done) begin
                        r_state   <= c_DOWN;
                        r_cnt     <= c_CNT_ZERO;
                        key_flag  <= 1'b1;
                        key_state <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_DOWN: begin
                    r_cnt <= c_CNT_ZERO;
                    if (w_pedge) begin
                        r_state <= c_FILTER1;
                    end
                end
                c_FILTER1: begin
                    if (w_nedge) begin
                        r_state <= c_DOWN;
                        r_cnt   <= c_CNT_ZERO;
                    end else if (w_cnt_done) begin
                        r_state   <= c_IDLE;
                        r_cnt     <= c_CNT_ZERO;
                        key_flag  <= 1'b1;
                        key_state <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= c_CNT_ZERO;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
